// File: rtl/board_sequencer.sv
// Run controller for the marble board: drops one ball at a time from the
// blue/red supplies, records each landed ball's colour in the tray, and
// ends the run on supply exhaustion or on a lost ball.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | after reset, waiting for start
// RELEASE | one cycle: pulse the release for sel_color, or end if empty
// FLIGHT  | ball on the board, waiting for a lever hit or timeout
// HALT    | run finished, everything held until start
module board_sequencer #(
    parameter int AMOUNT_BLUE    = 8,
    parameter int AMOUNT_RED     = 8,
    parameter int TRAY_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  start_color,
    input  logic                  blue_req,
    input  logic                  red_req,
    output logic                  blue_release,
    output logic                  red_release,
    output logic                  in_flight,
    output logic                  current_color,
    output logic [4:0]            blues_left,
    output logic [4:0]            reds_left,
    output logic [TRAY_DEPTH-1:0] tray,
    output logic [5:0]            tray_count,
    output logic                  done,
    output logic                  timeout
);

    typedef enum logic [1:0] {IDLE, RELEASE, FLIGHT, HALT} state_t;

    localparam logic [4:0]  BLUE_INIT  = 5'(AMOUNT_BLUE);
    localparam logic [4:0]  RED_INIT   = 5'(AMOUNT_RED);
    localparam logic [5:0]  TRAY_SLOTS = 6'(TRAY_DEPTH);
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic        sel_color;
    logic [15:0] timer;
    logic        blue_req_q, red_req_q;
    logic        blue_ev, red_ev;
    logic        capture_start, reload, fire, empty_end, land, land_color, lost;
    logic        supply_ok;

    assign blue_ev   = blue_req & ~blue_req_q;
    assign red_ev    = red_req & ~red_req_q;
    assign supply_ok = sel_color ? (reds_left != 5'd0) : (blues_left != 5'd0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        state_next    = state;
        blue_release  = 1'b0;
        red_release   = 1'b0;
        in_flight     = 1'b0;
        capture_start = 1'b0;
        reload        = 1'b0;
        fire          = 1'b0;
        empty_end     = 1'b0;
        land          = 1'b0;
        land_color    = 1'b0;
        lost          = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture_start = 1'b1;
                    state_next    = RELEASE;
                end
            end
            RELEASE: begin
                if (supply_ok) begin
                    fire         = 1'b1;
                    blue_release = ~sel_color;
                    red_release  = sel_color;
                    state_next   = FLIGHT;
                end else begin
                    empty_end  = 1'b1;
                    state_next = HALT;
                end
            end
            FLIGHT: begin
                in_flight = 1'b1;
                if (blue_ev || red_ev) begin
                    // Blue takes priority when both levers rise together.
                    land       = 1'b1;
                    land_color = ~blue_ev;
                    state_next = RELEASE;
                end else if (timer == TIMER_LAST) begin
                    lost       = 1'b1;
                    state_next = HALT;
                end
            end
            HALT: begin
                if (start) begin
                    capture_start = 1'b1;
                    reload        = 1'b1;
                    state_next    = RELEASE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Supplies, tray, flight timer and run status.
    always_ff @(posedge clk) begin
        if (rst) begin
            blue_req_q    <= 1'b0;
            red_req_q     <= 1'b0;
            sel_color     <= 1'b0;
            current_color <= 1'b0;
            blues_left    <= BLUE_INIT;
            reds_left     <= RED_INIT;
            tray          <= '0;
            tray_count    <= '0;
            timer         <= '0;
            done          <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            blue_req_q <= blue_req;
            red_req_q  <= red_req;
            if (capture_start) sel_color <= start_color;
            if (reload) begin
                blues_left <= BLUE_INIT;
                reds_left  <= RED_INIT;
                tray       <= '0;
                tray_count <= '0;
                done       <= 1'b0;
                timeout    <= 1'b0;
            end
            if (fire) begin
                if (sel_color) reds_left  <= reds_left - 5'd1;
                else           blues_left <= blues_left - 5'd1;
                current_color <= sel_color;
                timer         <= '0;
            end else if (state == FLIGHT) begin
                timer <= timer + 16'd1;
            end
            if (land) begin
                sel_color <= land_color;
                // Slots are cleared before a run, so OR-ing in the bit is a write.
                if (tray_count < TRAY_SLOTS) begin
                    tray       <= tray | (TRAY_DEPTH'(current_color) << tray_count);
                    tray_count <= tray_count + 6'd1;
                end
            end
            if (empty_end) done <= 1'b1;
            if (lost) begin
                done    <= 1'b1;
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_board_sequencer.sv
// Bench for board_sequencer: a vector table on a small-tray, short-timeout
// instance plus a hand sequence on a single-blue-ball instance.
module tb_board_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: TRAY_DEPTH=2, TIMEOUT_CYCLES=16
    logic a_rst = 1'b1, a_start = 1'b0, a_sc = 1'b0, a_breq = 1'b0, a_rreq = 1'b0;
    logic a_br, a_rr, a_fl, a_cur, a_done, a_tmo;
    logic [4:0] a_bl, a_rd;
    logic [1:0] a_tray;
    logic [5:0] a_cnt;

    board_sequencer #(.AMOUNT_BLUE(8), .AMOUNT_RED(8), .TRAY_DEPTH(2), .TIMEOUT_CYCLES(16)) dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .start_color(a_sc),
        .blue_req(a_breq), .red_req(a_rreq),
        .blue_release(a_br), .red_release(a_rr), .in_flight(a_fl), .current_color(a_cur),
        .blues_left(a_bl), .reds_left(a_rd), .tray(a_tray), .tray_count(a_cnt),
        .done(a_done), .timeout(a_tmo)
    );

    // Instance B: AMOUNT_BLUE=1
    logic b_rst = 1'b1, b_start = 1'b0, b_sc = 1'b0, b_breq = 1'b0, b_rreq = 1'b0;
    logic b_br, b_rr, b_fl, b_cur, b_done, b_tmo;
    logic [4:0] b_bl, b_rd;
    logic [15:0] b_tray;
    logic [5:0] b_cnt;

    board_sequencer #(.AMOUNT_BLUE(1), .AMOUNT_RED(8), .TRAY_DEPTH(16), .TIMEOUT_CYCLES(1024)) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .start_color(b_sc),
        .blue_req(b_breq), .red_req(b_rreq),
        .blue_release(b_br), .red_release(b_rr), .in_flight(b_fl), .current_color(b_cur),
        .blues_left(b_bl), .reds_left(b_rd), .tray(b_tray), .tray_count(b_cnt),
        .done(b_done), .timeout(b_tmo)
    );

    typedef struct {
        int         reps;
        logic       rst, start, sc, breq, rreq;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[$];

    // {blue_rel, red_rel, in_flight, cur, blues, reds, tray, count, done, timeout}
    function automatic logic [23:0] pk(logic br, logic rr, logic fl, logic cur, int bl, int rd,
                                       logic [1:0] tr, int cnt, logic d, logic t);
        return {br, rr, fl, cur, 5'(bl), 5'(rd), tr, 6'(cnt), d, t};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(int reps, logic rst, logic start, logic sc, logic breq, logic rreq,
                       logic [23:0] exp);
        vec_t v;
        v.reps = reps; v.rst = rst; v.start = start; v.sc = sc;
        v.breq = breq; v.rreq = rreq; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        //   reps rst st sc  b  r     br rr fl cur bl rd tray  cnt d  t
        add(1,  1, 0, 0, 0, 0, pk(0, 0, 0, 0, 8, 8, 2'b00, 0, 0, 0)); // reset state
        add(1,  0, 1, 1, 0, 0, pk(0, 1, 0, 0, 8, 8, 2'b00, 0, 0, 0)); // red release k+1
        add(1,  0, 0, 0, 0, 0, pk(0, 0, 1, 1, 8, 7, 2'b00, 0, 0, 0)); // in flight
        add(1,  0, 0, 0, 1, 0, pk(1, 0, 0, 1, 8, 7, 2'b01, 1, 0, 0)); // blue hit, red lands
        add(1,  0, 0, 0, 1, 0, pk(0, 0, 1, 0, 7, 7, 2'b01, 1, 0, 0)); // held lever once
        add(1,  0, 0, 0, 1, 1, pk(0, 1, 0, 0, 7, 7, 2'b01, 2, 0, 0)); // red hit, tray full
        add(1,  0, 0, 0, 1, 1, pk(0, 0, 1, 1, 7, 6, 2'b01, 2, 0, 0));
        add(1,  0, 0, 0, 0, 0, pk(0, 0, 1, 1, 7, 6, 2'b01, 2, 0, 0));
        add(1,  0, 0, 0, 1, 1, pk(1, 0, 0, 1, 7, 6, 2'b01, 2, 0, 0)); // both rise: blue wins
        add(4,  0, 0, 0, 1, 1, pk(0, 0, 1, 0, 6, 6, 2'b01, 2, 0, 0)); // held: no more pulses
        add(1,  0, 1, 1, 0, 0, pk(0, 0, 1, 0, 6, 6, 2'b01, 2, 0, 0)); // start in flight ignored
        add(11, 0, 0, 0, 0, 0, pk(0, 0, 1, 0, 6, 6, 2'b01, 2, 0, 0));
        add(1,  0, 0, 0, 0, 0, pk(0, 0, 0, 0, 6, 6, 2'b01, 2, 1, 1)); // timeout
        add(2,  0, 0, 0, 1, 0, pk(0, 0, 0, 0, 6, 6, 2'b01, 2, 1, 1)); // halt ignores levers
        add(1,  0, 1, 0, 0, 0, pk(1, 0, 0, 0, 8, 8, 2'b00, 0, 0, 0)); // restart reloads
        add(15, 0, 0, 0, 0, 0, pk(0, 0, 1, 0, 7, 8, 2'b00, 0, 0, 0));
        add(1,  0, 0, 0, 0, 0, pk(0, 0, 1, 0, 7, 8, 2'b00, 0, 0, 0)); // timer at last value
        add(1,  0, 0, 0, 0, 0, pk(0, 0, 0, 0, 7, 8, 2'b00, 0, 1, 1)); // 16 cycles -> timeout
        add(1,  0, 1, 0, 0, 0, pk(1, 0, 0, 0, 8, 8, 2'b00, 0, 0, 0));
        add(1,  0, 0, 0, 0, 0, pk(0, 0, 1, 0, 7, 8, 2'b00, 0, 0, 0));
        add(1,  1, 0, 0, 0, 0, pk(0, 0, 0, 0, 8, 8, 2'b00, 0, 0, 0)); // reset in flight
        add(1,  0, 1, 1, 0, 0, pk(0, 1, 0, 0, 8, 8, 2'b00, 0, 0, 0));
        add(1,  1, 0, 0, 0, 0, pk(0, 0, 0, 0, 8, 8, 2'b00, 0, 0, 0)); // reset in release
        add(1,  0, 0, 0, 0, 0, pk(0, 0, 0, 0, 8, 8, 2'b00, 0, 0, 0)); // no late pulse
        add(1,  0, 0, 0, 1, 0, pk(0, 0, 0, 0, 8, 8, 2'b00, 0, 0, 0)); // idle ignores levers
        add(1,  0, 1, 1, 1, 0, pk(0, 1, 0, 0, 8, 8, 2'b00, 0, 0, 0));
        add(1,  0, 0, 0, 0, 0, pk(0, 0, 1, 1, 8, 7, 2'b00, 0, 0, 0));
        add(1,  0, 0, 0, 0, 1, pk(0, 1, 0, 1, 8, 7, 2'b01, 1, 0, 0)); // red hit
        add(1,  0, 0, 0, 0, 1, pk(0, 0, 1, 1, 8, 6, 2'b01, 1, 0, 0));

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                a_rst = vecs[i].rst; a_start = vecs[i].start; a_sc = vecs[i].sc;
                a_breq = vecs[i].breq; a_rreq = vecs[i].rreq;
                step();
                chk($sformatf("vec%0d_rep%0d", i, r),
                    {8'd0, a_br, a_rr, a_fl, a_cur, a_bl, a_rd, a_tray, a_cnt, a_done, a_tmo},
                    {8'd0, vecs[i].exp});
            end
        end

        // Single blue ball: supply exhaustion ends the run.
        b_rst = 1'b1; step();
        chk("b_reset_supply", {22'd0, b_bl, b_rd}, {22'd0, 5'd1, 5'd8});
        b_rst = 1'b0; b_start = 1'b1; b_sc = 1'b1; step();
        chk("b_red_release", {30'd0, b_br, b_rr}, 32'd1);
        b_start = 1'b0; step();
        chk("b_flight_red", {24'd0, b_fl, b_cur, 1'b0, b_rd}, {24'd0, 1'b1, 1'b1, 1'b0, 5'd7});
        b_breq = 1'b1; step();
        chk("b_blue_release", {24'd0, b_br, b_rr, b_cnt}, {24'd0, 1'b1, 1'b0, 6'd1});
        chk("b_tray0_red", {16'd0, b_tray}, 32'h0001);
        b_breq = 1'b0; step();
        chk("b_flight_blue", {24'd0, b_fl, b_cur, 1'b0, b_bl}, {24'd0, 1'b1, 1'b0, 1'b0, 5'd0});
        b_breq = 1'b1; step();
        chk("b_empty_no_pulse", {24'd0, b_br, b_rr, b_cnt}, {24'd0, 1'b0, 1'b0, 6'd2});
        chk("b_tray1_blue", {16'd0, b_tray}, 32'h0001);
        b_breq = 1'b0; step();
        chk("b_empty_done", {28'd0, b_done, b_tmo, b_fl, b_br}, {28'd0, 4'b1000});
        step();
        chk("b_halt_hold", {24'd0, b_done, b_cnt, b_br}, {24'd0, 1'b1, 6'd2, 1'b0});
        b_start = 1'b1; b_sc = 1'b0; step();
        chk("b_restart_release", {30'd0, b_br, b_rr}, 32'd2);
        chk("b_restart_clear", {10'd0, b_bl, b_rd, b_cnt, b_done, b_tmo},
            {10'd0, 5'd1, 5'd8, 6'd0, 1'b0, 1'b0});
        chk("b_restart_tray", {16'd0, b_tray}, 32'd0);
        b_start = 1'b0; step();
        chk("b_blue_flight", {24'd0, b_fl, 2'b0, b_bl}, {24'd0, 1'b1, 2'b0, 5'd0});
        b_breq = 1'b1; step();
        chk("b_blue_hit_empty", {24'd0, b_br, b_rr, b_cnt}, {24'd0, 1'b0, 1'b0, 6'd1});
        b_breq = 1'b0; step();
        chk("b_blue_halt", {28'd0, b_done, b_tmo, b_fl, b_br}, {28'd0, 4'b1000});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
